imem_loader: RTL and testbench

- Writer side of the instruction-memory path: receives a program as a byte stream and writes 32-bit words into an instruction RAM.
- The instruction fetch side reads that RAM at byte addresses starting at 0x00400000.
- Holds the processor in reset while loading and releases it once the complete image is written.
- Sits between the byte-stream source (UART RX or testbench) and the instruction RAM write port.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Byte-stream program loader for the instruction RAM; holds the CPU
//            in reset until a length-prefixed big-endian image is fully written.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_rst_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [1:0]            r_bcnt;
    logic [DATA_WIDTH-9:0] r_shift;
    logic [DATA_WIDTH-1:0] r_count;
    logic [31:0]           r_idx;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_start_ok;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_accept    = rx_valid && rx_ready;
    assign w_word      = {r_shift, rx_data};
    assign w_word_done = w_accept && (r_bcnt == 2'd3);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_last      = (r_idx == (r_count - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_HDR;
            end
            S_HDR: begin
                if (w_word_done) begin
                    if (w_word == '0)                              w_next = S_DONE;
                    else if (w_word > DATA_WIDTH'(ADDR_WIDTH))     w_next = S_ERR;
                    else                                           w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_done && w_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = (r_state == S_HDR) || (r_state == S_DATA);
    end

    // Byte assembly: the shift register keeps the first three bytes of a word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= 2'd0;
            r_shift <= '0;
            r_count <= '0;
            r_idx   <= 32'd0;
        end else if (w_start_ok) begin
            r_bcnt  <= 2'd0;
            r_shift <= '0;
            r_idx   <= 32'd0;
        end else if (w_accept) begin
            r_bcnt  <= r_bcnt + 2'd1;
            r_shift <= w_word[DATA_WIDTH-9:0];
            if (w_word_done && (r_state == S_HDR))  r_count <= w_word;
            if (w_word_done && (r_state == S_DATA)) r_idx   <= r_idx + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
        end else begin
            wr_en <= w_word_done && (r_state == S_DATA);
            if (w_word_done && (r_state == S_DATA)) begin
                wr_addr <= BASE_ADDR + (r_idx << 2);
                wr_data <= w_word;
            end
        end
    end

    // CPU reset is released only from a settled DONE, one cycle after the last write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            busy      <= (w_next == S_HDR) || (w_next == S_DATA);
            done      <= (w_next == S_DONE);
            err       <= (w_next == S_ERR);
            cpu_rst_n <= (r_state == S_DONE) && (w_next == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Randomized self-checking bench for imem_loader with an image-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] BASE_ADDR  = 32'h0040_0000;
    localparam int          ADDR_WIDTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    imem_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: the only writer of these variables
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int   cyc      = 0;
    int   last_wr  = -10;
    int   rise_cyc = -10;
    int   dbl      = 0;
    logic prev_wr  = 1'b0;
    logic prev_cr  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            last_wr = cyc;
            if (prev_wr) dbl++;
        end
        if (cpu_rst_n && !prev_cr) rise_cyc = cyc;
        prev_wr = wr_en;
        prev_cr = cpu_rst_n;
    end

    logic [31:0] img[64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    task automatic send_word(input logic [31:0] w, input int mode);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] tmp;
            tmp = w << (8 * j);
            send_byte(tmp[31:24], pick_gap(mode));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   {31'd0, wr_en},     32'd0);
        check({tag, "_wr_addr"}, wr_addr,            BASE_ADDR);
        check({tag, "_wr_data"}, wr_data,            32'd0);
        check({tag, "_busy"},    {31'd0, busy},      32'd0);
        check({tag, "_done"},    {31'd0, done},      32'd0);
        check({tag, "_err"},     {31'd0, err},       32'd0);
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst_n}, 32'd0);
        check({tag, "_rx_rdy"},  {31'd0, rx_ready},  32'd0);
    endtask

    // Model: header N=0 -> done, no writes; N>ADDR_WIDTH -> err, no writes;
    // otherwise word i lands at BASE_ADDR + 4*i, then done and CPU released.
    task automatic run_load(input int n, input int mode);
        int  n0;
        int  exp_writes;
        bit  ok;
        bit  is_err;
        ok         = (n >= 1) && (n <= ADDR_WIDTH);
        is_err     = (n > ADDR_WIDTH);
        exp_writes = ok ? n : 0;
        n0         = obs_addr.size();
        pulse_start();
        check("start_busy",    {31'd0, busy},      32'd1);
        check("start_done",    {31'd0, done},      32'd0);
        check("start_err",     {31'd0, err},       32'd0);
        check("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
        send_word(n, mode);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                send_word(img[i], mode);
                check("wr_en_lat", {31'd0, wr_en}, 32'd1);
                if (i == n - 1) check("cpu_rst_early", {31'd0, cpu_rst_n}, 32'd0);
            end
        end
        repeat (3) tick();
        check("n_writes", obs_addr.size() - n0, exp_writes);
        for (int i = 0; i < exp_writes && (n0 + i) < obs_addr.size(); i++) begin
            check("wr_addr", obs_addr[n0 + i], BASE_ADDR + 32'(4 * i));
            check("wr_data", obs_data[n0 + i], img[i]);
        end
        check("end_done",    {31'd0, done},      {31'd0, !is_err});
        check("end_err",     {31'd0, err},       {31'd0, is_err});
        check("end_busy",    {31'd0, busy},      32'd0);
        check("end_cpu_rst", {31'd0, cpu_rst_n}, {31'd0, !is_err});
        check("end_rx_rdy",  {31'd0, rx_ready},  32'd0);
        check("end_wr_en",   {31'd0, wr_en},     32'd0);
        check("wr_pulse_1c", dbl, 32'd0);
        if (ok) check("cpu_rst_delay", rise_cyc, last_wr + 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rx_valid = 1'b1;
        #1;
        check_reset_outputs("rst");
        repeat (3) tick();
        check("idle_wr_en", {31'd0, wr_en}, 32'd0);
        check("idle_rx_rdy", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

        img[0] = 32'h2408_0005;
        img[1] = 32'h2009_000A;
        run_load(2, 0);
        run_load(2, 5);
        run_load(65, 0);
        run_load(0, 0);
        img[0] = 32'hDEAD_BEEF;
        run_load(1, 0);

        for (int k = 0; k < 64; k++) img[k] = $urandom;
        run_load(64, 0);
        repeat (6) begin
            int n;
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) img[k] = $urandom;
            run_load(n, -1);
        end

        // Reset in the middle of word index 1, then a clean 1-word load
        img[0] = 32'h1122_3344;
        img[1] = 32'h5566_7788;
        pulse_start();
        send_word(32'd2, 0);
        send_word(img[0], 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        img[0] = $urandom;
        run_load(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
